// File: rtl/uart_ocram_dp.sv
// -----------------------------------------------------------------------------
// uart_ocram_dp
//
// True-dual-port on-chip RAM for the UART subsystem. Two independent Avalon-MM
// slave ports (s1, s2) share one inferred memory array. Features:
//   * per-byte write enables
//   * a readdatavalid pipeline of READ_LATENCY (1 or 2) output stages behind
//     the registered RAM read
//   * cross-port same-address write merge, where s1 wins on overlapping bytes
//   * mixed-port read-during-write returns the old word
//
// Optional feature (macro UART_OCRAM_PARITY_EN):
//   * one even-parity bit is stored per byte
//   * parity is checked on every read
//   * a sticky parity_err output reports any mismatch
//
// Parameters:
//   DATA_WIDTH   : word width, multiple of 8
//   ADDR_WIDTH   : word address width (depth = 2**ADDR_WIDTH)
//   READ_LATENCY : 1 or 2 output register stages
//   INIT_FILE    : power-up image for the vendor memory-initialisation flow
//
// Ports:
//   clk, reset (async, active-high)
//   clken, reset_req : global stall; either one freezes both ports
//   sN_address, sN_byteenable, sN_chipselect, sN_read, sN_write,
//   sN_writedata, sN_readdata, sN_readdatavalid (N = 1, 2)
//   collision        : one-cycle pulse when s2 write bytes are overridden
//   parity_err       : sticky parity error (UART_OCRAM_PARITY_EN only)
// -----------------------------------------------------------------------------
module uart_ocram_dp #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 15,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "uart_ocram_dp.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    reset_req,

    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,

    output logic                    collision
`ifdef UART_OCRAM_PARITY_EN
    ,
    output logic                    parity_err
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef UART_OCRAM_PARITY_EN
    localparam int MW    = DATA_WIDTH + NB;  // parity bits sit above the data
`else
    localparam int MW    = DATA_WIDTH;
`endif

    // Port signals gathered into arrays so both ports share one generate body.
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [NB-1:0]         be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [1:0]            cs;
    logic [1:0]            rd;
    logic [1:0]            wr;

    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;
    assign cs       = {s2_chipselect, s1_chipselect};
    assign rd       = {s2_read, s1_read};
    assign wr       = {s2_write, s1_write};

    logic       en;
    logic [1:0] do_wr;
    logic [1:0] do_rd;
    logic       same_addr;
    logic [NB-1:0] s2_keep;
    logic       collision_next;

    assign en    = clken & ~reset_req;
    assign do_wr = {2{en}} & cs & wr;
    // A write on the same port takes precedence; the read is dropped.
    assign do_rd = {2{en}} & cs & rd & ~wr;

    assign same_addr = (addr[0] == addr[1]);
    // s2 keeps only the bytes s1 is not writing to the same word.
    assign s2_keep   = be[1] & ~(be[0] & {NB{do_wr[0] & same_addr}});
    assign collision_next = do_wr[0] & do_wr[1] & same_addr & (|(be[0] & be[1]));

    // -------------------------------------------------------------------------
    // Memory array. Never reset; contents come from the initialisation image.
    // Because overlapping s2 bytes are masked out, no location is written
    // twice on one edge.
    // -------------------------------------------------------------------------
    logic [MW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (do_wr[0] && be[0][b]) begin
                mem[addr[0]][8*b +: 8] <= wdata[0][8*b +: 8];
`ifdef UART_OCRAM_PARITY_EN
                mem[addr[0]][DATA_WIDTH+b] <= ^wdata[0][8*b +: 8];
`endif
            end
            if (do_wr[1] && s2_keep[b]) begin
                mem[addr[1]][8*b +: 8] <= wdata[1][8*b +: 8];
`ifdef UART_OCRAM_PARITY_EN
                mem[addr[1]][DATA_WIDTH+b] <= ^wdata[1][8*b +: 8];
`endif
            end
        end
    end

`ifdef UART_OCRAM_PARITY_EN
    // Even parity: each stored bit plus its byte must XOR to zero.
    function automatic logic parity_bad(input logic [MW-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < NB; b++) begin
            bad = bad | (^{w[DATA_WIDTH+b], w[8*b +: 8]});
        end
        return bad;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Per-port read path:
    //   registered RAM read -> optional middle stage -> output register.
    // Every stage advances only on enabled edges, so a stall freezes the
    // whole pipeline in place.
    // -------------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        logic [MW-1:0]         ram_q_reg;
        logic                  ram_v_reg;
        logic [MW-1:0]         pre_q;
        logic                  pre_v;
        logic [DATA_WIDTH-1:0] dout_reg;
        logic                  dv_reg;

        // Registered read; the non-blocking write above keeps this the old word.
        always_ff @(posedge clk) begin
            if (do_rd[gi]) begin
                ram_q_reg <= mem[addr[gi]];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ram_v_reg <= 1'b0;
            end else if (en) begin
                ram_v_reg <= do_rd[gi];
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic [MW-1:0] mid_q_reg;
            logic          mid_v_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mid_v_reg <= 1'b0;
                    mid_q_reg <= '0;
                end else if (en) begin
                    mid_v_reg <= ram_v_reg;
                    if (ram_v_reg) begin
                        mid_q_reg <= ram_q_reg;
                    end
                end
            end

            assign pre_q = mid_q_reg;
            assign pre_v = mid_v_reg;
        end else begin : g_lat1
            assign pre_q = ram_q_reg;
            assign pre_v = ram_v_reg;
        end

        // Output data loads only alongside a valid, so it holds in between.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dv_reg   <= 1'b0;
                dout_reg <= '0;
            end else if (en) begin
                dv_reg <= pre_v;
                if (pre_v) begin
                    dout_reg <= pre_q[DATA_WIDTH-1:0];
                end
            end
        end

`ifdef UART_OCRAM_PARITY_EN
        // Pulses on the edge that raises this port's readdatavalid.
        logic perr;
        assign perr = en & pre_v & parity_bad(pre_q);
`endif
    end

    assign s1_readdata      = g_port[0].dout_reg;
    assign s1_readdatavalid = g_port[0].dv_reg;
    assign s2_readdata      = g_port[1].dout_reg;
    assign s2_readdatavalid = g_port[1].dv_reg;

    // Collision is a pure one-cycle pulse: it clears on the next edge even
    // while the ports are stalled.
    logic collision_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= collision_next;
        end
    end
    assign collision = collision_reg;

`ifdef UART_OCRAM_PARITY_EN
    logic parity_err_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_reg <= 1'b0;
        end else if (g_port[0].perr || g_port[1].perr) begin
            parity_err_reg <= 1'b1;
        end
    end
    assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_ocram_dp.sv
// -----------------------------------------------------------------------------
// Testbench for uart_ocram_dp.
//
// Two instances are driven from one stimulus stream:
//   * g_dut[0] uses READ_LATENCY = 1
//   * g_dut[1] uses READ_LATENCY = 2
//
// A behavioural model keeps the following state:
//   * a word array updated with the byte-merge rules
//   * one queue per instance/port of pending reads, each tagged with the
//     enabled-edge count at which it must surface
//
// All outputs of both instances are compared after every clock edge.
// -----------------------------------------------------------------------------
module tb_uart_ocram_dp;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic clken;
    logic reset_req;
    logic [1:0][AW-1:0] t_addr;
    logic [1:0][NB-1:0] t_be;
    logic [1:0]         t_cs;
    logic [1:0]         t_rd;
    logic [1:0]         t_wr;
    logic [1:0][DW-1:0] t_wd;

    logic [1:0][1:0][DW-1:0] rdo;  // [instance][port]
    logic [1:0][1:0]         rvo;
    logic [1:0]              coll;
    logic [1:0]              perr;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_dut
        uart_ocram_dp #(
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (AW),
            .READ_LATENCY(gi + 1),
            .INIT_FILE   ("")
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .clken           (clken),
            .reset_req       (reset_req),
            .s1_address      (t_addr[0]),
            .s1_byteenable   (t_be[0]),
            .s1_chipselect   (t_cs[0]),
            .s1_read         (t_rd[0]),
            .s1_write        (t_wr[0]),
            .s1_writedata    (t_wd[0]),
            .s1_readdata     (rdo[gi][0]),
            .s1_readdatavalid(rvo[gi][0]),
            .s2_address      (t_addr[1]),
            .s2_byteenable   (t_be[1]),
            .s2_chipselect   (t_cs[1]),
            .s2_read         (t_rd[1]),
            .s2_write        (t_wr[1]),
            .s2_writedata    (t_wd[1]),
            .s2_readdata     (rdo[gi][1]),
            .s2_readdatavalid(rvo[gi][1]),
            .collision       (coll[gi])
`ifdef UART_OCRAM_PARITY_EN
            ,
            .parity_err      (perr[gi])
`endif
        );
`ifndef UART_OCRAM_PARITY_EN
        assign perr[gi] = 1'b0;
`endif
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        int            due;
        logic          bad;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] ref_mem [256];
    bit            corrupt [256];  // parity bit flipped in instance 0
    rd_t           rq [4][$];
    int            ecnt;
    logic [1:0][1:0]         exp_v;
    logic [1:0][1:0][DW-1:0] exp_d;
    logic                    exp_coll;
    logic [1:0]              exp_perr;

    int tests = 0;
    int fails = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) rq[i].delete();
        exp_v    = '0;
        exp_d    = '0;
        exp_coll = 1'b0;
        exp_perr = '0;
        ecnt     = 0;
    endtask

    // Applies the effect of the coming clock edge to the model.
    task automatic model_edge();
        logic [DW-1:0] old [2];
        bit            take [2];
        bit            bad [2];
        int            i;
        if (!(clken && !reset_req)) begin
            exp_coll = 1'b0;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            take[p] = t_cs[p] && t_rd[p] && !t_wr[p];
            old[p]  = ref_mem[t_addr[p]];
            bad[p]  = corrupt[t_addr[p]];
        end
        exp_coll = t_cs[0] && t_wr[0] && t_cs[1] && t_wr[1] &&
                   (t_addr[0] == t_addr[1]) && ((t_be[0] & t_be[1]) != 0);
        // s2 first, then s1 on top: s1 owns every byte it enables.
        for (int p = 1; p >= 0; p--) begin
            if (t_cs[p] && t_wr[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (t_be[p][b]) begin
                        ref_mem[t_addr[p]][8*b +: 8] = t_wd[p][8*b +: 8];
                        if (b == 0) corrupt[t_addr[p]] = 1'b0;
                    end
                end
            end
        end
        ecnt++;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                i = d * 2 + p;
                exp_v[d][p] = 1'b0;
                if (rq[i].size() > 0 && rq[i][0].due == ecnt) begin
                    exp_v[d][p] = 1'b1;
                    exp_d[d][p] = rq[i][0].data;
                    if (rq[i][0].bad) exp_perr[d] = 1'b1;
                    void'(rq[i].pop_front());
                end
                if (take[p]) begin
                    rq[i].push_back('{due: ecnt + d + 1, bad: (d == 0) && bad[p], data: old[p]});
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("lat%0d_s%0d_valid", d + 1, p + 1), {31'd0, rvo[d][p]}, {31'd0, exp_v[d][p]});
                chk($sformatf("lat%0d_s%0d_data", d + 1, p + 1), rdo[d][p], exp_d[d][p]);
            end
            chk($sformatf("lat%0d_collision", d + 1), {31'd0, coll[d]}, {31'd0, exp_coll});
`ifdef UART_OCRAM_PARITY_EN
            chk($sformatf("lat%0d_parity_err", d + 1), {31'd0, perr[d]}, {31'd0, exp_perr[d]});
`endif
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        t_cs = '0;
        t_rd = '0;
        t_wr = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
        t_cs[p]   = 1'b1;
        t_wr[p]   = 1'b1;
        t_rd[p]   = 1'b0;
        t_addr[p] = a;
        t_wd[p]   = d;
        t_be[p]   = b;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        t_cs[p]   = 1'b1;
        t_rd[p]   = 1'b1;
        t_wr[p]   = 1'b0;
        t_addr[p] = a;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk_all();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #2;
        chk_all();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        clken     = 1'b1;
        reset_req = 1'b0;
        t_addr    = '0;
        t_be      = '0;
        t_wd      = '0;
        idle();
        for (int a = 0; a < 256; a++) corrupt[a] = 1'b0;
        model_reset();
        #12;
        chk_all();                          // reset values
        reset = 1'b0;

        // Give every word a defined value.
        for (int a = 0; a < 128; a++) begin
            wr(0, AW'(2 * a), $urandom, '1);
            wr(1, AW'(2 * a + 1), $urandom, '1);
            cycle();
        end

        // Write then read back.
        wr(0, 8'h10, 32'hDEADBEEF, 4'hF); cycle();
        rd(0, 8'h10); cycle();
        cycle();
        chk("tp_readback_data", rdo[0][0], 32'hDEADBEEF);
        chk("tp_readback_valid", {31'd0, rvo[0][0]}, 32'd1);
        cycle();
        chk("tp_readback_lat2", rdo[1][0], 32'hDEADBEEF);

        // Byte merge.
        wr(0, 8'h20, 32'h11223344, 4'hF); cycle();
        wr(1, 8'h20, 32'hAABBCCDD, 4'h5); cycle();
        rd(0, 8'h20); cycle();
        cycle();
        chk("tp_byte_merge", rdo[0][0], 32'h11BB33DD);

        // Cross-port collision.
        wr(0, 8'h30, 32'h12345678, 4'hF); cycle();
        wr(0, 8'h30, 32'h000000FF, 4'h1);
        wr(1, 8'h30, 32'hFFFFFF00, 4'h3); cycle();
        chk("tp_collision_pulse", {31'd0, coll[0]}, 32'd1);
        rd(1, 8'h30); cycle();
        chk("tp_collision_clear", {31'd0, coll[0]}, 32'd0);
        cycle();
        chk("tp_collision_word", rdo[0][1], 32'h1234FFFF);

        // Mixed-port read during write returns the old word.
        wr(0, 8'h40, 32'h1, 4'hF); cycle();
        rd(1, 8'h40);
        wr(0, 8'h40, 32'h2, 4'hF); cycle();
        cycle();
        chk("tp_rdw_old", rdo[0][1], 32'h1);
        rd(1, 8'h40); cycle();
        cycle();
        chk("tp_rdw_new", rdo[0][1], 32'h2);

        // Same-port read+write: write only, no valid.
        wr(0, 8'h41, 32'h5A5A5A5A, 4'hF);
        t_rd[0] = 1'b1; cycle();
        cycle(); cycle();

        // Stall in the middle of a read burst.
        rd(0, 8'h00); cycle();
        rd(0, 8'h01); cycle();
        clken = 1'b0;
        repeat (3) cycle();
        clken = 1'b1;
        rd(0, 8'h02); cycle();
        repeat (4) cycle();

        // Reset with a read in flight.
        rd(0, 8'h05); rd(1, 8'h06); cycle();
        do_reset();
        repeat (3) cycle();

        // Randomised traffic over a small window to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                t_cs[p]   = ($urandom % 4) != 0;
                t_rd[p]   = $urandom % 2;
                t_wr[p]   = ($urandom % 3) == 0;
                t_addr[p] = AW'($urandom % 16);
                t_be[p]   = NB'($urandom);
                t_wd[p]   = $urandom;
            end
            clken     = ($urandom % 8) != 0;
            reset_req = ($urandom % 16) == 0;
            cycle();
        end
        clken     = 1'b1;
        reset_req = 1'b0;
        repeat (3) cycle();

`ifdef UART_OCRAM_PARITY_EN
        // Flip a stored parity bit in the latency-1 instance only.
        g_dut[0].u_dut.mem[8'h50][DW] = ~g_dut[0].u_dut.mem[8'h50][DW];
        corrupt[8'h50] = 1'b1;
        rd(0, 8'h50); cycle();
        cycle();
        chk("tp_parity_set", {31'd0, perr[0]}, 32'd1);
        repeat (3) cycle();
        chk("tp_parity_sticky", {31'd0, perr[0]}, 32'd1);
        do_reset();
        chk("tp_parity_clear", {31'd0, perr[0]}, 32'd0);
        cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
